// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift_sequencer command stage.
//   DATA_W   : operand width handled by the external barrel_shifter
//   STEP_MAX : largest amount the barrel_shifter applies in one pass. It is
//              fixed by the 2-bit shift_value port, so do not change it.
//   state_t  : sequencer FSM states
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  localparam int DATA_W   = 4;
  localparam int STEP_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the command port, the response port and the barrel_shifter side
// channel of shift_sequencer.
//   cmd_*  : command valid/ready with operand, amount, rotate and left flags
//   rsp_*  : result valid/ready with result data
//   sh_*   : drive/capture of the external combinational barrel_shifter
//   busy   : sequencer is in RUN or DONE
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (command source, result sink, shifter)
// -----------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int AMT_W = 4
);
  import shift_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [AMT_W-1:0]  cmd_amount;
  logic              cmd_rotate;
  logic              cmd_left;

  logic              sh_select;
  logic              sh_direction;
  logic [1:0]        sh_amount;
  logic [DATA_W-1:0] sh_din;
  logic [DATA_W-1:0] sh_dout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  logic              busy;

  modport slave (
    input  cmd_valid, cmd_data, cmd_amount, cmd_rotate, cmd_left,
    output cmd_ready,
    output sh_select, sh_direction, sh_amount, sh_din,
    input  sh_dout,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_data, cmd_amount, cmd_rotate, cmd_left,
    input  cmd_ready,
    input  sh_select, sh_direction, sh_amount, sh_din,
    output sh_dout,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Breaks a shift/rotate command of up to 2^AMT_W-1 bits into passes of at most
// STEP_MAX bits through an external 4-bit combinational barrel_shifter. The
// shifter output is captured into the working register every RUN cycle; the
// final pass result is returned on the response port.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : shift_sequencer_if.slave (cmd_*, rsp_*, sh_*, busy)
// Optional feature (macro SHIFT_SEQ_ROT_MOD_EN):
//   When defined, a rotate command keeps only amount mod 4 at accept, so a
//   rotate needs at most one pass. Results are the same; only latency changes.
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    bus
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] work_reg, work_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic [AMT_W-1:0]  remaining_reg, remaining_next;
  logic              rot_reg, rot_next;
  logic              left_reg, left_next;

  logic [AMT_W-1:0]  amount_eff;
  logic [1:0]        step;
  logic              last_pass;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      rsp_data_reg  <= '0;
      remaining_reg <= '0;
      rot_reg       <= 1'b0;
      left_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      rsp_data_reg  <= rsp_data_next;
      remaining_reg <= remaining_next;
      rot_reg       <= rot_next;
      left_reg      <= left_next;
    end
  end

  // Amount actually iterated for an incoming command. Rotating by 4 is the
  // identity on a 4-bit word, so only the low two bits of a rotate matter.
  always_comb begin
`ifdef SHIFT_SEQ_ROT_MOD_EN
    amount_eff = bus.cmd_rotate ? AMT_W'(bus.cmd_amount[1:0]) : bus.cmd_amount;
`else
    amount_eff = bus.cmd_amount;
`endif
  end

  // Per-pass step is min(remaining, STEP_MAX); the pass that consumes the
  // rest of the amount is the last one.
  assign last_pass = (remaining_reg <= AMT_W'(STEP_MAX));
  assign step      = last_pass ? remaining_reg[1:0] : 2'(STEP_MAX);

  always_comb begin
    state_next       = state_reg;
    work_next        = work_reg;
    rsp_data_next    = rsp_data_reg;
    remaining_next   = remaining_reg;
    rot_next         = rot_reg;
    left_next        = left_reg;
    bus.sh_select    = 1'b0;
    bus.sh_direction = 1'b0;
    bus.sh_amount    = 2'd0;
    bus.sh_din       = '0;

    unique case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          work_next      = bus.cmd_data;
          remaining_next = amount_eff;
          rot_next       = bus.cmd_rotate;
          left_next      = bus.cmd_left;
          if (amount_eff == '0) begin
            rsp_data_next = bus.cmd_data;
            state_next    = DONE;
          end else begin
            state_next    = RUN;
          end
        end
      end

      RUN: begin
        bus.sh_select    = rot_reg;
        bus.sh_direction = left_reg;
        bus.sh_amount    = step;
        bus.sh_din       = work_reg;
        work_next        = bus.sh_dout;
        remaining_next   = remaining_reg - AMT_W'(step);
        if (last_pass) begin
          rsp_data_next = bus.sh_dout;
          state_next    = DONE;
        end
      end

      DONE: begin
        // cmd_ready stays low here, so a new command waits for IDLE.
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == DONE);
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed plus random commands against shift_sequencer with a behavioural
// barrel_shifter on the sh_* channel. Expected results go into a scoreboard
// queue at accept and are compared when rsp_valid appears. Build with
// SHIFT_SEQ_ROT_MOD_EN defined to match the RTL when the feature is enabled.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int AMT_W = 4;

  typedef struct {
    logic [3:0] data;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_sequencer_if #(.AMT_W(AMT_W)) bus();

  shift_sequencer #(.AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  exp_t sb[$];
  int   sh_seq[$];

  // Reference result of a complete command, computed in one step.
  function automatic logic [3:0] ref_op(logic [3:0] d, int amt, logic rot, logic left);
    logic [7:0] dd;
    logic [7:0] t;
    logic [3:0] s;
    if (rot) begin
      dd = {d, d};
      if (left) begin
        t = dd << (amt % 4);
        return t[7:4];
      end else begin
        t = dd >> (amt % 4);
        return t[3:0];
      end
    end
    if (amt >= 4) return 4'b0000;
    s = left ? (d << amt) : (d >> amt);
    return s;
  endfunction

  // External combinational barrel_shifter (select 1 = rotate, direction 1 = left).
  always_comb bus.sh_dout = ref_op(bus.sh_din, int'(bus.sh_amount), bus.sh_select, bus.sh_direction);

  // Records the step size of each RUN cycle.
  always @(negedge clk) begin
    if (rst_n && bus.busy && !bus.rsp_valid) sh_seq.push_back(int'(bus.sh_amount));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] d, input int amt, input logic rot, input logic left,
                         input logic [3:0] exp_d, input int hold);
    int   eff, n, edges, last;
    exp_t got;
    logic [3:0] held;
`ifdef SHIFT_SEQ_ROT_MOD_EN
    eff = rot ? (amt % 4) : amt;
`else
    eff = amt;
`endif
    n = (eff + 2) / 3;
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = d;
    bus.cmd_amount = AMT_W'(amt);
    bus.cmd_rotate = rot;
    bus.cmd_left   = left;
    bus.rsp_ready  = (hold == 0);
    sb.push_back('{exp_d, n + 1});
    sh_seq.delete();
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = 4'($urandom);
    bus.cmd_amount = AMT_W'($urandom);
    bus.cmd_rotate = 1'($urandom);
    bus.cmd_left   = 1'($urandom);
    while (!bus.rsp_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("rsp_valid", bus.rsp_valid, 1);
    got = sb.pop_front();
    $display("cmd d=%b amt=%0d rot=%0d left=%0d -> rsp=%b after %0d edges (exp %b, %0d)",
             d, amt, rot, left, bus.rsp_data, edges, got.data, got.lat);
    check("rsp_data", bus.rsp_data, got.data);
    check("latency", edges, got.lat);
    check("pass_count", sh_seq.size(), n);
    last = eff - 3 * (n - 1);
    for (int i = 0; i < sh_seq.size() && i < n; i++)
      check("sh_amount_pass", sh_seq[i], (i < n - 1) ? 3 : last);
    check("sh_amount_done", bus.sh_amount, 0);
    if (hold > 0) begin
      held = bus.rsp_data;
      for (int k = 0; k < hold; k++) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_data   = ~held;
        bus.cmd_amount = '0;
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        check("bp_rsp_data", bus.rsp_data, held);
        check("bp_cmd_ready", bus.cmd_ready, 0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", bus.rsp_valid, 0);
      check("bp_release_ready", bus.cmd_ready, 1);
      check("bp_release_busy", bus.busy, 0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.cmd_amount = '0;
    bus.cmd_rotate = 1'b0;
    bus.cmd_left   = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sh_amount", bus.sh_amount, 0);
    rst_n = 1'b1;

    // Directed cases.
    run_cmd(4'b1001, 1, 1'b1, 1'b1, 4'b0011, 0);
    run_cmd(4'b1111, 5, 1'b0, 1'b0, 4'b0000, 0);
    run_cmd(4'b0001, 7, 1'b1, 1'b0, 4'b0010, 0);
    run_cmd(4'b1010, 0, 1'b0, 1'b1, 4'b1010, 0);
    run_cmd(4'b0001, 15, 1'b1, 1'b1, 4'b1000, 0);
    run_cmd(4'b0110, 8, 1'b1, 1'b0, 4'b0110, 0);
    run_cmd(4'b0110, 6, 1'b1, 1'b1, 4'b1001, 5);

    // Reset in the middle of a 15-bit shift drops the command.
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = 4'b1111;
    bus.cmd_amount = AMT_W'(15);
    bus.cmd_rotate = 1'b0;
    bus.cmd_left   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_run_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_rsp_data", bus.rsp_data, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_sh_din", bus.sh_din, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("postrst_cmd_ready", bus.cmd_ready, 1);
    check("postrst_rsp_valid", bus.rsp_valid, 0);
    $display("reset during RUN: cmd_ready=%0d rsp_valid=%0d", bus.cmd_ready, bus.rsp_valid);

    // Random commands.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] rd;
      int         ra;
      logic       rr, rl;
      rd = 4'($urandom);
      ra = int'($urandom_range(0, 15));
      rr = 1'($urandom);
      rl = 1'($urandom);
      run_cmd(rd, ra, rr, rl, ref_op(rd, ra, rr, rl), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Upstream command stage for the 4-bit combinational barrel_shifter. It accepts shift/rotate commands with amounts up to 2^AMT_W-1 over a valid/ready handshake. Because barrel_shifter handles at most 3 bits per pass, the block breaks each command into passes of at most 3 bits. It drives the barrel_shifter inputs, captures barrel_shifter dout into a working register each cycle, and returns the final result on a valid/ready response port.

Parameters:
AMT_W, 4, width of the command shift amount (max amount 2^AMT_W-1)
STEP_MAX, 3, max bits per pass; fixed by the barrel_shifter shift_value width; do not override

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept command
cmd_data  in  4  operand
cmd_amount  in  AMT_W  total bits to shift/rotate
cmd_rotate  in  1  0=shift (zero fill), 1=rotate
cmd_left  in  1  0=right, 1=left
sh_select  out  1  to barrel_shifter select
sh_direction  out  1  to barrel_shifter direction
sh_amount  out  2  to barrel_shifter shift_value
sh_din  out  4  to barrel_shifter din
sh_dout  in  4  from barrel_shifter dout
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  4  result
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, rsp_valid=0, rsp_data=4'b0000, busy=0. Working regs clear to 0. sh_* outputs are 0. Reset overrides everything, including mid-RUN or DONE; an in-flight command is dropped with no response.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready, latch work=cmd_data, remaining=cmd_amount, rot=cmd_rotate, left=cmd_left.
  - If cmd_amount==0, go to DONE with rsp_data=cmd_data. Otherwise go to RUN.
- RUN:
  - cmd_ready=0.
  - Combinational outputs: sh_din=work, sh_select=rot, sh_direction=left, sh_amount=min(remaining,3).
  - Each edge: work<=sh_dout; remaining<=remaining-sh_amount.
  - If remaining<=3, this is the last pass: go to DONE, rsp_data<=sh_dout, rsp_valid<=1.
- DONE:
  - rsp_valid=1. rsp_data holds stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE with rsp_valid<=0. cmd_ready rises the following cycle; no same-cycle accept in DONE.
- In IDLE and DONE, sh_amount=0, sh_din=0, sh_select=0, sh_direction=0.
- Latency:
  - N = ceil(amount/3) passes.
  - rsp_valid rises on the (N+1)th edge, counting the accept edge as 1. Amount 0 gives 1 cycle.
  - Throughput is one command per N+2 cycles minimum.
- Shift mode with amount >= 4 iterates normally and yields 0000; no shortcut.
- Max amount (15) takes 5 passes: 3,3,3,3,3.
- cmd_* is ignored while cmd_ready=0. Inputs need not be held after acceptance.

Optional Feature:
SHIFT_SEQ_ROT_MOD_EN:
- Defined: at accept, when cmd_rotate=1, remaining<=cmd_amount mod 4. Rotates therefore take at most 1 pass, and a rotate by a multiple of 4 goes straight to DONE with latency 1. Shift commands are unchanged.
- Undefined: rotates iterate on the full amount as above.
- Results are identical either way; only latency differs.

Decomposition:
- Package shift_seq_pkg: state enum (IDLE, RUN, DONE), DATA_W=4, STEP_MAX=3.
- No internal sub-module. barrel_shifter stays outside and is wired alongside (top-level or bench) via the sh_* ports. The FSM and datapath live in one module.

Test Plan:
- Rotate left 1 of 4'b1001, rsp_ready=1 -> 1 pass, rsp_valid on 2nd edge, rsp_data=4'b0011.
- Shift right 5 of 4'b1111 -> sh_amount sequence 3 then 2, rsp_valid on 3rd edge, rsp_data=4'b0000.
- Rotate right 7 of 4'b0001:
  - Without SHIFT_SEQ_ROT_MOD_EN: sh_amount 3,3,1, work 0010, 0100, 0010, rsp_data=4'b0010 on 4th edge.
  - With SHIFT_SEQ_ROT_MOD_EN: 1 pass, same data, on 2nd edge.
- Amount 0 with cmd_data=4'b1010 -> rsp_valid on 1st edge, rsp_data=4'b1010, sh_amount stays 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_valid stable, cmd_ready=0, a second cmd_valid is not accepted. After rsp_ready=1, cmd_ready=1 the next cycle.
- rst_n=0 during RUN of a 15-bit shift -> next edge state IDLE, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1 after rst_n release.
